// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator and its per-voice envelopes.
// Also holds the MIDI key-to-frequency lookup.
package synth_pkg;

  localparam int NUM_VOICES_DEF = 8;

  typedef enum logic [1:0] {
    V_OFF     = 2'd0,
    V_ATTACK  = 2'd1,
    V_SUSTAIN = 2'd2,
    V_RELEASE = 2'd3
  } voice_state_e;

  typedef enum logic [1:0] {
    CMD_NEW     = 2'd0,
    CMD_RETRIG  = 2'd1,
    CMD_RELEASE = 2'd2
  } voice_cmd_e;

  // Octave keys 60..71 held in micro-Hz, scaled by 2^(octave-5) with rounding.
  function automatic logic [31:0] key_to_hz(input logic [6:0] key);
    logic [3:0]  oct;
    logic [3:0]  note;
    logic [31:0] base;
    logic [31:0] hz;
    oct  = 4'(key / 7'd12);
    note = 4'(key % 7'd12);
    case (note)
      4'd0:    base = 32'd261625565;
      4'd1:    base = 32'd277182631;
      4'd2:    base = 32'd293664768;
      4'd3:    base = 32'd311126984;
      4'd4:    base = 32'd329627557;
      4'd5:    base = 32'd349228231;
      4'd6:    base = 32'd369994423;
      4'd7:    base = 32'd391995436;
      4'd8:    base = 32'd415304698;
      4'd9:    base = 32'd440000000;
      4'd10:   base = 32'd466163762;
      default: base = 32'd493883301;
    endcase
    hz = 32'((({32'd0, base} << oct) + 64'd16000000) / 64'd32000000);
    if (hz < 32'd8) hz = 32'd8;
    return hz;
  endfunction

endpackage

// File: rtl/voice_envelope.sv
// One synthesizer voice: envelope state, volume, target, key and frequency.
// A commit from the allocator takes priority over an envelope tick in the same cycle.
module voice_envelope
  import synth_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        env_tick_i,
  input  logic [31:0] attack_step_i,
  input  logic [31:0] release_step_i,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [6:0]  cmd_key_i,
  input  logic [31:0] cmd_freq_i,
  input  logic [31:0] cmd_target_i,
  output logic [1:0]  state_o,
  output logic [6:0]  key_o,
  output logic [31:0] volume_o,
  output logic [31:0] freq_o
);

  voice_state_e state_q, state_d;
  logic [31:0]  vol_q, vol_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  freq_q, freq_d;
  logic [6:0]   key_q, key_d;
  logic [32:0]  sum;

  assign sum = {1'b0, vol_q} + {1'b0, attack_step_i};

  always_comb begin
    state_d = state_q;
    vol_d   = vol_q;
    tgt_d   = tgt_q;
    freq_d  = freq_q;
    key_d   = key_q;
    if (cmd_valid_i) begin
      case (cmd_op_i)
        CMD_NEW: begin
          state_d = V_ATTACK;
          vol_d   = '0;
          tgt_d   = cmd_target_i;
          freq_d  = cmd_freq_i;
          key_d   = cmd_key_i;
        end
        CMD_RETRIG: begin
          state_d = V_ATTACK;
          tgt_d   = cmd_target_i;
        end
        default: state_d = V_RELEASE;
      endcase
    end else if (env_tick_i) begin
      case (state_q)
        V_ATTACK: begin
          if (attack_step_i == '0 || sum >= {1'b0, tgt_q}) begin
            vol_d   = tgt_q;
            state_d = V_SUSTAIN;
          end else begin
            vol_d = sum[31:0];
          end
        end
        V_RELEASE: begin
          if (release_step_i == '0 || vol_q <= release_step_i) begin
            vol_d   = '0;
            state_d = V_OFF;
          end else begin
            vol_d = vol_q - release_step_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= V_OFF;
      vol_q   <= '0;
      tgt_q   <= '0;
      freq_q  <= 32'd440;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      vol_q   <= vol_d;
      tgt_q   <= tgt_d;
      freq_q  <= freq_d;
      key_q   <= key_d;
    end
  end

  assign state_o  = state_q;
  assign key_o    = key_q;
  assign volume_o = vol_q;
  assign freq_o   = freq_q;

endmodule

// File: rtl/voice_allocator.sv
// Note-event allocator: scans one voice per cycle to pick a retrigger, free or
// steal target (or all matching voices for note-off), then commits in one cycle.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = NUM_VOICES_DEF,
  parameter int VOLUME_SHIFT = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    note_valid,
  output logic                    note_ready,
  input  logic                    note_on,
  input  logic [6:0]              note_key,
  input  logic [6:0]              note_velocity,
  input  logic                    env_tick,
  input  logic [31:0]             attack_step,
  input  logic [31:0]             release_step,
  output logic [32*NUM_VOICES-1:0] frequencies,
  output logic [32*NUM_VOICES-1:0] voice_volumes,
  output logic [NUM_VOICES-1:0]   voice_active
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} alloc_state_e;

  alloc_state_e          state_q, state_d;
  logic                  ready_q, ready_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  ev_on_q, ev_on_d;
  logic [6:0]            ev_key_q, ev_key_d;
  logic [6:0]            ev_vel_q, ev_vel_d;
  logic                  rt_found_q, rt_found_d;
  logic [IW-1:0]         rt_idx_q, rt_idx_d;
  logic                  off_found_q, off_found_d;
  logic [IW-1:0]         off_idx_q, off_idx_d;
  logic [IW-1:0]         min_idx_q, min_idx_d;
  logic [31:0]           min_vol_q, min_vol_d;
  logic [NUM_VOICES-1:0] rel_mask_q, rel_mask_d;

  logic [1:0]            v_state [NUM_VOICES];
  logic [6:0]            v_key   [NUM_VOICES];
  logic [31:0]           v_vol   [NUM_VOICES];
  logic [31:0]           v_freq  [NUM_VOICES];
  logic [NUM_VOICES-1:0] cmd_valid;
  logic [1:0]            cmd_op;
  logic [31:0]           cmd_target;
  logic [31:0]           cmd_freq;

  logic [1:0]            cur_state;
  logic [6:0]            cur_key;
  logic [31:0]           cur_vol;
  logic                  cur_held;

  assign cur_state  = v_state[idx_q];
  assign cur_key    = v_key[idx_q];
  assign cur_vol    = v_vol[idx_q];
  assign cur_held   = (cur_state == V_ATTACK || cur_state == V_SUSTAIN) && cur_key == ev_key_q;
  assign cmd_target = 32'(ev_vel_q) << VOLUME_SHIFT;
  assign cmd_freq   = key_to_hz(ev_key_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ev_on_d     = ev_on_q;
    ev_key_d    = ev_key_q;
    ev_vel_d    = ev_vel_q;
    rt_found_d  = rt_found_q;
    rt_idx_d    = rt_idx_q;
    off_found_d = off_found_q;
    off_idx_d   = off_idx_q;
    min_idx_d   = min_idx_q;
    min_vol_d   = min_vol_q;
    rel_mask_d  = rel_mask_q;
    cmd_valid   = '0;
    cmd_op      = CMD_NEW;
    case (state_q)
      S_IDLE: begin
        if (note_valid && ready_q) begin
          state_d     = S_SCAN;
          idx_d       = '0;
          ev_on_d     = note_on && (note_velocity != 7'd0);
          ev_key_d    = note_key;
          ev_vel_d    = note_velocity;
          rt_found_d  = 1'b0;
          off_found_d = 1'b0;
          rel_mask_d  = '0;
          min_idx_d   = '0;
          min_vol_d   = '1;
        end
      end
      S_SCAN: begin
        if (cur_held && !rt_found_q) begin
          rt_found_d = 1'b1;
          rt_idx_d   = idx_q;
        end
        if (cur_state == V_OFF && !off_found_q) begin
          off_found_d = 1'b1;
          off_idx_d   = idx_q;
        end
        // Strict compare keeps the lowest index on equal volumes.
        if (idx_q == '0 || cur_vol < min_vol_q) begin
          min_idx_d = idx_q;
          min_vol_d = cur_vol;
        end
        rel_mask_d[idx_q] = cur_held;
        if (idx_q == IW'(NUM_VOICES - 1)) state_d = S_COMMIT;
        else                              idx_d   = idx_q + 1'b1;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (!ev_on_q) begin
          cmd_op    = CMD_RELEASE;
          cmd_valid = rel_mask_q;
        end else if (rt_found_q) begin
          cmd_op              = CMD_RETRIG;
          cmd_valid[rt_idx_q] = 1'b1;
        end else if (off_found_q) begin
          cmd_valid[off_idx_q] = 1'b1;
        end else begin
          cmd_valid[min_idx_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      idx_q       <= '0;
      ev_on_q     <= 1'b0;
      ev_key_q    <= '0;
      ev_vel_q    <= '0;
      rt_found_q  <= 1'b0;
      rt_idx_q    <= '0;
      off_found_q <= 1'b0;
      off_idx_q   <= '0;
      min_idx_q   <= '0;
      min_vol_q   <= '0;
      rel_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      idx_q       <= idx_d;
      ev_on_q     <= ev_on_d;
      ev_key_q    <= ev_key_d;
      ev_vel_q    <= ev_vel_d;
      rt_found_q  <= rt_found_d;
      rt_idx_q    <= rt_idx_d;
      off_found_q <= off_found_d;
      off_idx_q   <= off_idx_d;
      min_idx_q   <= min_idx_d;
      min_vol_q   <= min_vol_d;
      rel_mask_q  <= rel_mask_d;
    end
  end

  assign note_ready = ready_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_envelope u_env (
      .clk            (clk),
      .reset_n        (reset_n),
      .env_tick_i     (env_tick),
      .attack_step_i  (attack_step),
      .release_step_i (release_step),
      .cmd_valid_i    (cmd_valid[g]),
      .cmd_op_i       (cmd_op),
      .cmd_key_i      (ev_key_q),
      .cmd_freq_i     (cmd_freq),
      .cmd_target_i   (cmd_target),
      .state_o        (v_state[g]),
      .key_o          (v_key[g]),
      .volume_o       (v_vol[g]),
      .freq_o         (v_freq[g])
    );
    assign frequencies[32*g +: 32]   = v_freq[g];
    assign voice_volumes[32*g +: 32] = v_vol[g];
    assign voice_active[g]           = (v_state[g] != V_OFF);
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, number of voices driven (matches downstream synthesizer).
REQ-002 SHALL have parameter VOLUME_SHIFT, default 24, left shift applied to velocity to form the volume target.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 note_valid  in  1  note event present.
REQ-006 note_ready  out  1  allocator can accept an event.
REQ-007 note_on  in  1  1 = note-on, 0 = note-off.
REQ-008 note_key  in  7  MIDI key number 0..127.
REQ-009 note_velocity  in  7  MIDI velocity 0..127.
REQ-010 env_tick  in  1  one-cycle envelope step strobe.
REQ-011 attack_step  in  32  unsigned volume increment per tick.
REQ-012 release_step  in  32  unsigned volume decrement per tick.
REQ-013 frequencies  out  32 x NUM_VOICES  per-voice frequency in Hz, registered.
REQ-014 voice_volumes  out  32 x NUM_VOICES  per-voice unsigned volume, registered.
REQ-015 voice_active  out  NUM_VOICES  1 where voice state is not OFF.

Function
REQ-016 Event accepted on cycle T when note_valid and note_ready both high; key/velocity/on captured at T.
REQ-017 Control FSM: IDLE -> SCAN (NUM_VOICES cycles, one voice examined per cycle, index 0 first) -> COMMIT (1 cycle) -> IDLE.
REQ-018 note_ready high only in IDLE; low from T+1 through T+NUM_VOICES+1; updated voice visible on outputs and note_ready high at T+NUM_VOICES+2.
REQ-019 note_on with velocity 0 treated as note-off.
REQ-020 Note-on target selection priority: (a) lowest-index voice with same key in ATTACK or SUSTAIN (retrigger); (b) lowest-index OFF voice; (c) voice with lowest current volume, ties to lowest index (steal).
REQ-021 Retrigger: state -> ATTACK, target = velocity << VOLUME_SHIFT, current volume kept.
REQ-022 New or stolen voice: frequency = table[key], volume -> 0, state -> ATTACK, target as REQ-021.
REQ-023 Note-off: every voice with matching key in ATTACK or SUSTAIN -> RELEASE at COMMIT; no match -> no change, FSM still completes SCAN/COMMIT.
REQ-024 Per-voice envelope states OFF, ATTACK, SUSTAIN, RELEASE; all voices step in parallel only on cycles where env_tick is high.
REQ-025 ATTACK tick: volume = min(volume + attack_step, target), 33-bit sum, no wrap; reaching target -> SUSTAIN; attack_step 0 -> volume = target immediately.
REQ-026 RELEASE tick: volume = max(volume - release_step, 0), no underflow; reaching 0 -> OFF; release_step 0 -> volume 0, OFF on that tick.
REQ-027 SUSTAIN and OFF ignore env_tick.
REQ-028 env_tick coinciding with COMMIT: committed voice takes COMMIT update and drops that tick; other voices tick normally.
REQ-029 Frequency table: round(440 * 2^((key-69)/12)) Hz, minimum 8; frequency never 0 (downstream divides by it); OFF voices keep last frequency.
REQ-030 Step inputs sampled on the tick cycle; changes mid-envelope take effect on next tick.

Reset
REQ-031 reset_n low asynchronously forces: FSM IDLE, note_ready 0 while low and 1 on first clock after release, all voices OFF, voice_volumes 0, voice_active 0, frequencies 440.
REQ-032 Reset during SCAN/COMMIT abandons the in-flight event with no voice modified.

Structure
REQ-033 Shared package synth_pkg SHALL hold NUM_VOICES default, voice state enum, and the 128-entry key-to-Hz table function.
REQ-034 One sub-module voice_envelope (per-voice state, volume, target, frequency) instantiated NUM_VOICES times; allocator FSM in top.

Verification
REQ-035 Reset, then note-on key 69 vel 100, attack_step 2^31 -> voice 0 frequency 440, active, note_ready back at T+10; one tick -> volume 100<<24, SUSTAIN.
REQ-036 Nine note-ons keys 60..68 vel 127, no ticks -> ninth steals voice 0 (all volumes 0, tie to index 0), frequencies[0]=415.
REQ-037 Note-off key 60 with release_step 2^30 from volume 127<<24 -> RELEASE, OFF after 2 ticks, volume 0, voice_active bit clears.
REQ-038 Note-on key 72 twice -> second retriggers same voice, no second voice active; velocity 0 note-on on key 72 -> RELEASE.
REQ-039 env_tick asserted on COMMIT cycle with two ATTACK voices -> committed voice volume 0, other voice advanced by attack_step.
REQ-040 reset_n pulsed low mid-SCAN -> outputs reach reset values without clock edge; no voice changed after release.
